noc_output_port_scheduler: RTL

Per-output-port switch scheduler for the mesh router. It shares one router output port among the five input ports (east, west, south, north, local) using round-robin arbitration with wormhole locking: the port is held from a head flit to its tail flit. It also tracks downstream credit per virtual channel, so a flit is granted only when the next hop has buffer space. One instance sits on each active output port of every router; it drives the crossbar select and the output valid.

---
 rtl/noc_output_port_scheduler_pkg.sv | 25 ++
 rtl/noc_rr_arbiter.sv | 31 +++
 rtl/noc_output_port_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/noc_output_port_scheduler_pkg.sv
// Shared router parameters and types for the output-port scheduler.
// Port indices follow the active-port bit order used across the mesh.
package noc_output_port_scheduler_pkg;

    localparam int Noc_Port_Num     = 5;
    localparam int Noc_VC_Num       = 2;
    localparam int Noc_Credit_Depth = 4;
    localparam int Noc_VC_W         = (Noc_VC_Num > 1) ? $clog2(Noc_VC_Num) : 1;

    typedef enum logic [2:0] {
        PORT_EAST  = 3'd0,
        PORT_WEST  = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_NORTH = 3'd3,
        PORT_LOCAL = 3'd4
    } noc_port_e;

    typedef logic [Noc_VC_W-1:0] noc_vc_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward (wrapping)
// and returns the first requester as a one-hot grant plus its index.
module noc_rr_arbiter #(
    parameter int NUM_IN = 5,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = (int'(ptr) + k) % NUM_IN;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/noc_output_port_scheduler.sv
// Output-port switch scheduler: round-robin head arbitration, wormhole lock
// from head to tail, and per-VC downstream credit tracking.
module noc_output_port_scheduler
    import noc_output_port_scheduler_pkg::*;
#(
    parameter int NUM_IN       = Noc_Port_Num,
    parameter int NUM_VC       = Noc_VC_Num,
    parameter int CREDIT_DEPTH = Noc_Credit_Depth,
    localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1),
    localparam int SEL_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    noc_clk,
    input  logic                    noc_rst,
    input  logic [NUM_IN-1:0]       req_valid,
    input  logic [NUM_IN*VC_W-1:0]  req_vc,
    input  logic [NUM_IN-1:0]       req_head,
    input  logic [NUM_IN-1:0]       req_tail,
    input  logic [NUM_VC-1:0]       credit_return,
    output logic [NUM_IN-1:0]       grant,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic [VC_W-1:0]         out_vc,
    output logic                    locked,
    output logic [NUM_VC*CNT_W-1:0] credit_cnt,
    output logic                    proto_err
);

    sched_state_e      state_reg, state_next;
    logic [SEL_W-1:0]  rr_ptr_reg, owner_reg, arb_idx;
    logic [VC_W-1:0]   owner_vc_reg, arb_vc;
    logic [CNT_W-1:0]  credit_reg [NUM_VC];
    logic              proto_err_reg, err_set;

    logic [VC_W-1:0]   vc_in [NUM_IN];
    logic [NUM_IN-1:0] elig, head_cand, arb_grant;
    logic [NUM_VC-1:0] credit_ok, sent_vc, ovf_vc;
    logic              arb_any, arb_tail, owner_go;

    genvar gi;

    // Eligibility only matches VCs that exist, so an out-of-range req_vc is never granted.
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            assign vc_in[gi] = req_vc[gi*VC_W +: VC_W];
            always_comb begin
                elig[gi] = 1'b0;
                for (int v = 0; v < NUM_VC; v++) begin
                    if (vc_in[gi] == VC_W'(v) && credit_ok[v]) begin
                        elig[gi] = req_valid[gi];
                    end
                end
            end
        end
    endgenerate

    assign head_cand = elig & req_head;

    noc_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req   (head_cand),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign arb_vc   = vc_in[arb_idx];
    assign arb_tail = req_tail[arb_idx];
    assign owner_go = req_valid[owner_reg] && credit_ok[owner_vc_reg];

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= SEL_W'(NUM_IN - 1);
            owner_reg     <= '0;
            owner_vc_reg  <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            proto_err_reg <= proto_err_reg | err_set | (|ovf_vc);
            if (state_reg == ST_IDLE && arb_any) begin
                rr_ptr_reg   <= arb_idx;
                owner_reg    <= arb_idx;
                owner_vc_reg <= arb_vc;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (arb_any && !arb_tail) state_next = ST_LOCKED;
            ST_LOCKED: if (owner_go && req_tail[owner_reg]) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Body flits while idle and heads from the owner while locked are protocol errors.
    always_comb begin
        grant   = '0;
        out_sel = '0;
        out_vc  = '0;
        err_set = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                grant   = arb_grant;
                err_set = |(req_valid & ~req_head);
                if (arb_any) begin
                    out_sel = arb_idx;
                    out_vc  = arb_vc;
                end
            end
            ST_LOCKED: begin
                err_set = req_valid[owner_reg] && req_head[owner_reg];
                if (owner_go) begin
                    grant[owner_reg] = 1'b1;
                    out_sel          = owner_reg;
                    out_vc           = owner_vc_reg;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = |grant;
    assign locked    = (state_reg == ST_LOCKED);
    assign proto_err = proto_err_reg;

    // A return that would push a full counter past the buffer depth saturates instead.
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
            assign credit_ok[gi] = (credit_reg[gi] != '0);
            assign sent_vc[gi]   = out_valid && (out_vc == VC_W'(gi));
            assign ovf_vc[gi]    = credit_return[gi] && !sent_vc[gi]
                                   && (credit_reg[gi] == CNT_W'(CREDIT_DEPTH));
            assign credit_cnt[gi*CNT_W +: CNT_W] = credit_reg[gi];

            always_ff @(posedge noc_clk or posedge noc_rst) begin
                if (noc_rst) begin
                    credit_reg[gi] <= CNT_W'(CREDIT_DEPTH);
                end else if (sent_vc[gi] && !credit_return[gi]) begin
                    credit_reg[gi] <= credit_reg[gi] - 1'b1;
                end else if (!sent_vc[gi] && credit_return[gi] && !ovf_vc[gi]) begin
                    credit_reg[gi] <= credit_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

endmodule
